// File: rtl/wormhole_outport_alloc.sv
// Output-port stage of a wormhole NoC router: round-robin head arbitration, packet lock
// from head to tail, registered flit mux and downstream credit tracking.

module arbiter_priority_en #(
  parameter int ARBITER_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ARBITER_WIDTH-1:0] request,
  output logic [ARBITER_WIDTH-1:0] grant,
  output logic                     any_grant,
  input  logic                     priority_en
);
  localparam int PW = $clog2(ARBITER_WIDTH);

  // ptr_reg holds the last winner; search starts one past it
  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] grant_idx;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = ptr_reg;
    found     = 1'b0;
    for (int k = 1; k <= ARBITER_WIDTH; k++) begin
      if (!found && request[(int'(ptr_reg) + k) % ARBITER_WIDTH]) begin
        grant[(int'(ptr_reg) + k) % ARBITER_WIDTH] = 1'b1;
        grant_idx = PW'((int'(ptr_reg) + k) % ARBITER_WIDTH);
        found     = 1'b1;
      end
    end
  end

  assign any_grant = |request;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_reg <= PW'(ARBITER_WIDTH - 1);
    end else if (priority_en && any_grant) begin
      ptr_reg <= grant_idx;
    end
  end
endmodule

module wormhole_outport_alloc #(
  parameter int P            = 5,
  parameter int FW           = 32,
  parameter int CREDIT_DEPTH = 4,
  localparam int CW          = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [P-1:0]    req,
  input  logic [P-1:0]    hdr,
  input  logic [P-1:0]    tail,
  input  logic [P*FW-1:0] flit_in,
  output logic [P-1:0]    flit_ack,
  output logic [FW-1:0]   flit_out,
  output logic            flit_out_valid,
  input  logic            credit_in,
  output logic [CW-1:0]   credits,
  output logic            locked,
  output logic [P-1:0]    owner,
  output logic            credit_err
);
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state_reg;
  logic [P-1:0]    owner_reg;
  logic [CW-1:0]   credits_reg;
  logic            credit_err_reg;
  logic [FW-1:0]   flit_out_reg;
  logic            flit_out_valid_reg;

  logic            has_credit;
  logic [P-1:0]    arb_request;
  logic [P-1:0]    arb_grant;
  logic            arb_any_grant;
  logic            transfer;
  logic            is_tail;
  logic [FW-1:0]   sel_flit;
  logic [FW-1:0]   slice_masked [P];

  assign has_credit = (credits_reg != '0);

  arbiter_priority_en #(
    .ARBITER_WIDTH(P)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .request     (arb_request),
    .grant       (arb_grant),
    .any_grant   (arb_any_grant),
    .priority_en (arb_any_grant)
  );

  // Heads compete only while idle; a locked port serves its owner alone
  always_comb begin
    arb_request = '0;
    flit_ack    = '0;
    if (state_reg == IDLE) begin
      arb_request = req & hdr & {P{has_credit}};
      flit_ack    = arb_grant;
    end else if (has_credit && ((req & owner_reg) != '0)) begin
      flit_ack = owner_reg;
    end
  end

  assign transfer = |flit_ack;
  assign is_tail  = |(tail & flit_ack);

  // flit_ack is one-hot, so an AND-OR of the slices is the mux
  generate
    for (genvar gi = 0; gi < P; gi++) begin : g_slice
      assign slice_masked[gi] = flit_in[gi*FW +: FW] & {FW{flit_ack[gi]}};
    end
  endgenerate

  always_comb begin
    sel_flit = '0;
    for (int i = 0; i < P; i++) begin
      sel_flit = sel_flit | slice_masked[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg          <= IDLE;
      owner_reg          <= '0;
      credits_reg        <= CW'(CREDIT_DEPTH);
      credit_err_reg     <= 1'b0;
      flit_out_reg       <= '0;
      flit_out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (transfer && !is_tail) begin
            state_reg <= LOCKED;
            owner_reg <= flit_ack;
          end
        end
        LOCKED: begin
          if (transfer && is_tail) begin
            state_reg <= IDLE;
            owner_reg <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase

      flit_out_valid_reg <= transfer;
      if (transfer) begin
        flit_out_reg <= sel_flit;
      end

      // A transfer and a returned credit in the same cycle cancel out
      case ({transfer, credit_in})
        2'b10: credits_reg <= credits_reg - CW'(1);
        2'b01: begin
          if (credits_reg == CW'(CREDIT_DEPTH)) begin
            credit_err_reg <= 1'b1;
          end else begin
            credits_reg <= credits_reg + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign flit_out       = flit_out_reg;
  assign flit_out_valid = flit_out_valid_reg;
  assign credits        = credits_reg;
  assign locked         = (state_reg == LOCKED);
  assign owner          = owner_reg;
  assign credit_err     = credit_err_reg;
endmodule

// File: tb/tb_wormhole_outport_alloc.sv
// Directed bench for wormhole_outport_alloc: one depth-4 and one depth-2 instance
// sharing clock and reset.

module tb_wormhole_outport_alloc;
  localparam int P   = 5;
  localparam int FW  = 32;
  localparam int CW  = 3;
  localparam int CW2 = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;

  logic [P-1:0]    req = '0, hdr = '0, tail = '0;
  logic [P*FW-1:0] flit_in = '0;
  logic            credit_in = 1'b0;
  logic [P-1:0]    flit_ack, owner;
  logic [FW-1:0]   flit_out;
  logic            flit_out_valid, locked, credit_err;
  logic [CW-1:0]   credits;

  logic [P-1:0]    req2 = '0, hdr2 = '0, tail2 = '0;
  logic [P*FW-1:0] flit_in2 = '0;
  logic            credit_in2 = 1'b0;
  logic [P-1:0]    flit_ack2, owner2;
  logic [FW-1:0]   flit_out2;
  logic            flit_out_valid2, locked2, credit_err2;
  logic [CW2-1:0]  credits2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wormhole_outport_alloc #(.P(P), .FW(FW), .CREDIT_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .req(req), .hdr(hdr), .tail(tail), .flit_in(flit_in),
    .flit_ack(flit_ack), .flit_out(flit_out), .flit_out_valid(flit_out_valid),
    .credit_in(credit_in), .credits(credits), .locked(locked), .owner(owner),
    .credit_err(credit_err)
  );

  wormhole_outport_alloc #(.P(P), .FW(FW), .CREDIT_DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .req(req2), .hdr(hdr2), .tail(tail2), .flit_in(flit_in2),
    .flit_ack(flit_ack2), .flit_out(flit_out2), .flit_out_valid(flit_out_valid2),
    .credit_in(credit_in2), .credits(credits2), .locked(locked2), .owner(owner2),
    .credit_err(credit_err2)
  );

  task automatic put(input int i, input bit r, input bit h, input bit t, input logic [FW-1:0] d);
    req[i] = r; hdr[i] = h; tail[i] = t; flit_in[i*FW +: FW] = d;
  endtask

  task automatic put2(input int i, input bit r, input bit h, input bit t, input logic [FW-1:0] d);
    req2[i] = r; hdr2[i] = h; tail2[i] = t; flit_in2[i*FW +: FW] = d;
  endtask

  task automatic clear_inputs();
    req = '0; hdr = '0; tail = '0; flit_in = '0; credit_in = 1'b0;
    req2 = '0; hdr2 = '0; tail2 = '0; flit_in2 = '0; credit_in2 = 1'b0;
  endtask

  task automatic refill(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); credit_in = 1'b1;
    end
    @(negedge clk); credit_in = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %b want 0", locked); end
    n_cmp++; if (owner !== 5'b0) begin n_bad++; $display("FAIL reset_owner: got %b want 00000", owner); end
    n_cmp++; if (flit_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", flit_out_valid); end
    n_cmp++; if (flit_out !== 32'h0) begin n_bad++; $display("FAIL reset_flit_out: got %h want 0", flit_out); end
    n_cmp++; if (credits !== 3'd4) begin n_bad++; $display("FAIL reset_credits: got %0d want 4", credits); end
    n_cmp++; if (credit_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", credit_err); end
    n_cmp++; if (credits2 !== 2'd2) begin n_bad++; $display("FAIL reset_credits2: got %0d want 2", credits2); end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (flit_ack !== 5'b0 || locked !== 1'b0) begin
      n_bad++; $display("FAIL reset_idle: got ack=%b locked=%b want 00000/0", flit_ack, locked);
    end
    $display("reset: credits=%0d credits2=%0d", credits, credits2);
  endtask

  task automatic test_single_packet();
    logic [FW-1:0] exp_out;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      put(2, 1'b1, c == 0, c == 2, 32'hA0 + c);
      #1;
      n_cmp++; if (flit_ack !== 5'b00100) begin n_bad++; $display("FAIL single_ack c%0d: got %b want 00100", c, flit_ack); end
      @(posedge clk); #1;
      exp_out = 32'hA0 + c;
      $display("single: c%0d ack=%b out=%h valid=%b credits=%0d", c, flit_ack, flit_out, flit_out_valid, credits);
      n_cmp++; if (flit_out_valid !== 1'b1 || flit_out !== exp_out) begin
        n_bad++; $display("FAIL single_out c%0d: got %b/%h want 1/%h", c, flit_out_valid, flit_out, exp_out);
      end
      n_cmp++; if (locked !== (c != 2)) begin n_bad++; $display("FAIL single_locked c%0d: got %b want %b", c, locked, c != 2); end
      n_cmp++; if (credits !== CW'(3 - c)) begin n_bad++; $display("FAIL single_credits c%0d: got %0d want %0d", c, credits, 3 - c); end
    end
    @(negedge clk); clear_inputs(); #1;
    n_cmp++; if (flit_ack !== 5'b0) begin n_bad++; $display("FAIL single_idle_ack: got %b want 00000", flit_ack); end
    @(posedge clk); #1;
    n_cmp++; if (flit_out_valid !== 1'b0 || flit_out !== 32'hA2) begin
      n_bad++; $display("FAIL single_hold: got %b/%h want 0/000000a2", flit_out_valid, flit_out);
    end
    refill(3);
    @(posedge clk); #1;
    n_cmp++; if (credits !== 3'd4) begin n_bad++; $display("FAIL single_refill: got %0d want 4", credits); end
  endtask

  task automatic test_contention();
    // Last winner was input 2, so input 3 is next in round-robin order
    logic [P-1:0]  exp_ack [4] = '{5'b01000, 5'b01000, 5'b00001, 5'b00001};
    logic [P-1:0]  exp_own [4] = '{5'b01000, 5'b00000, 5'b00001, 5'b00000};
    logic [FW-1:0] exp_out [4] = '{32'hC0, 32'hC1, 32'hB0, 32'hB1};
    int idx0 = 0, idx3 = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      put(0, idx0 < 2, idx0 == 0, idx0 == 1, 32'hB0 + idx0);
      put(3, idx3 < 2, idx3 == 0, idx3 == 1, 32'hC0 + idx3);
      #1;
      n_cmp++; if (flit_ack !== exp_ack[c]) begin n_bad++; $display("FAIL contend_ack c%0d: got %b want %b", c, flit_ack, exp_ack[c]); end
      if (flit_ack[0]) idx0++;
      if (flit_ack[3]) idx3++;
      @(posedge clk); #1;
      $display("contend: c%0d out=%h owner=%b", c, flit_out, owner);
      n_cmp++; if (flit_out_valid !== 1'b1 || flit_out !== exp_out[c]) begin
        n_bad++; $display("FAIL contend_out c%0d: got %b/%h want 1/%h", c, flit_out_valid, flit_out, exp_out[c]);
      end
      n_cmp++; if (owner !== exp_own[c]) begin n_bad++; $display("FAIL contend_owner c%0d: got %b want %b", c, owner, exp_own[c]); end
    end
    @(negedge clk); clear_inputs();
    @(posedge clk); #1;
    n_cmp++; if (credits !== 3'd0) begin n_bad++; $display("FAIL contend_credits: got %0d want 0", credits); end
    refill(4);
    @(posedge clk); #1;
  endtask

  task automatic test_credit_stall();
    bit            cin [9]     = '{0, 0, 0, 0, 1, 0, 0, 1, 0};
    bit            e_ack [9]   = '{1, 1, 0, 0, 0, 1, 0, 0, 1};
    logic [1:0]    e_cred [9]  = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd0};
    logic [FW-1:0] e_out [9]   = '{32'hD0, 32'hD1, 32'hD1, 32'hD1, 32'hD1, 32'hD2, 32'hD2, 32'hD2, 32'hD3};
    logic [P-1:0]  want_ack;
    int idx = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      put2(1, idx < 4, idx == 0, idx == 3, 32'hD0 + idx);
      credit_in2 = cin[c];
      #1;
      want_ack = e_ack[c] ? 5'b00010 : 5'b00000;
      n_cmp++; if (flit_ack2 !== want_ack) begin n_bad++; $display("FAIL stall_ack c%0d: got %b want %b", c, flit_ack2, want_ack); end
      if (flit_ack2[1]) idx++;
      @(posedge clk); #1;
      $display("stall: c%0d valid=%b out=%h credits=%0d locked=%b", c, flit_out_valid2, flit_out2, credits2, locked2);
      n_cmp++; if (flit_out_valid2 !== e_ack[c] || flit_out2 !== e_out[c]) begin
        n_bad++; $display("FAIL stall_out c%0d: got %b/%h want %b/%h", c, flit_out_valid2, flit_out2, e_ack[c], e_out[c]);
      end
      n_cmp++; if (credits2 !== e_cred[c]) begin n_bad++; $display("FAIL stall_credits c%0d: got %0d want %0d", c, credits2, e_cred[c]); end
      n_cmp++; if (locked2 !== (c != 8)) begin n_bad++; $display("FAIL stall_locked c%0d: got %b want %b", c, locked2, c != 8); end
    end
    @(negedge clk); clear_inputs(); credit_in2 = 1'b1;
    @(negedge clk);
    @(negedge clk); credit_in2 = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (credits2 !== 2'd2 || credit_err2 !== 1'b0) begin
      n_bad++; $display("FAIL stall_refill: got %0d/%b want 2/0", credits2, credit_err2);
    end
  endtask

  task automatic test_simul_credit();
    logic [CW-1:0] e_cred [4] = '{3'd3, 3'd2, 3'd1, 3'd1};
    logic [FW-1:0] exp_out;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      put(4, 1'b1, 1'b1, 1'b1, 32'hE0 + k);
      credit_in = (k == 3);
      #1;
      n_cmp++; if (flit_ack !== 5'b10000) begin n_bad++; $display("FAIL simul_ack k%0d: got %b want 10000", k, flit_ack); end
      @(posedge clk); #1;
      exp_out = 32'hE0 + k;
      $display("simul: k%0d out=%h credits=%0d", k, flit_out, credits);
      n_cmp++; if (flit_out_valid !== 1'b1 || flit_out !== exp_out) begin
        n_bad++; $display("FAIL simul_out k%0d: got %b/%h want 1/%h", k, flit_out_valid, flit_out, exp_out);
      end
      n_cmp++; if (credits !== e_cred[k] || locked !== 1'b0) begin
        n_bad++; $display("FAIL simul_credits k%0d: got %0d/%b want %0d/0", k, credits, locked, e_cred[k]);
      end
    end
    @(negedge clk); clear_inputs();
    refill(3);
    @(posedge clk); #1;
  endtask

  task automatic test_credit_overflow();
    @(negedge clk); credit_in = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (credits !== 3'd4 || credit_err !== 1'b1) begin
      n_bad++; $display("FAIL overflow: got %0d/%b want 4/1", credits, credit_err);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); credit_in = 1'b0;
      put(1, 1'b1, 1'b0, 1'b0, 32'h55);
      #1;
      n_cmp++; if (flit_ack !== 5'b0) begin n_bad++; $display("FAIL nonhead_ack c%0d: got %b want 00000", c, flit_ack); end
      @(posedge clk); #1;
      $display("overflow: c%0d credits=%0d err=%b", c, credits, credit_err);
      n_cmp++; if (credit_err !== 1'b1 || flit_out_valid !== 1'b0 || credits !== 3'd4) begin
        n_bad++; $display("FAIL overflow_sticky c%0d: got %b/%b/%0d want 1/0/4", c, credit_err, flit_out_valid, credits);
      end
    end
    @(negedge clk); clear_inputs();
  endtask

  task automatic test_reset_mid_packet();
    @(negedge clk);
    put(1, 1'b1, 1'b1, 1'b0, 32'hF0);
    #1;
    n_cmp++; if (flit_ack !== 5'b00010) begin n_bad++; $display("FAIL midrst_ack: got %b want 00010", flit_ack); end
    @(posedge clk); #1;
    n_cmp++; if (locked !== 1'b1 || flit_out_valid !== 1'b1 || credits !== 3'd3) begin
      n_bad++; $display("FAIL midrst_pre: got %b/%b/%0d want 1/1/3", locked, flit_out_valid, credits);
    end
    reset = 1'b1;
    #1;
    $display("midrst: reset asserted locked=%b credits=%0d", locked, credits);
    n_cmp++; if (locked !== 1'b0 || owner !== 5'b0 || flit_out_valid !== 1'b0) begin
      n_bad++; $display("FAIL midrst_lock: got %b/%b/%b want 0/00000/0", locked, owner, flit_out_valid);
    end
    n_cmp++; if (credits !== 3'd4 || credit_err !== 1'b0) begin
      n_bad++; $display("FAIL midrst_credits: got %0d/%b want 4/0", credits, credit_err);
    end
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    put(3, 1'b1, 1'b1, 1'b0, 32'h60);
    #1;
    n_cmp++; if (flit_ack !== 5'b01000) begin n_bad++; $display("FAIL midrst_new_ack: got %b want 01000", flit_ack); end
    @(posedge clk); #1;
    n_cmp++; if (flit_out_valid !== 1'b1 || flit_out !== 32'h60 || owner !== 5'b01000) begin
      n_bad++; $display("FAIL midrst_new_out: got %b/%h/%b want 1/00000060/01000", flit_out_valid, flit_out, owner);
    end
    @(negedge clk);
    put(3, 1'b1, 1'b0, 1'b1, 32'h61);
    @(posedge clk); #1;
    $display("midrst: tail out=%h locked=%b", flit_out, locked);
    n_cmp++; if (flit_out !== 32'h61 || locked !== 1'b0 || credits !== 3'd2) begin
      n_bad++; $display("FAIL midrst_tail: got %h/%b/%0d want 00000061/0/2", flit_out, locked, credits);
    end
    @(negedge clk); clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_contention();
    test_credit_stall();
    test_simul_credit();
    test_credit_overflow();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wormhole_outport_alloc.md
Name: wormhole_outport_alloc

Overview:
- Output-port stage of the NoC router that sits directly downstream of the round-robin arbiter.
- Instantiates arbiter_priority_en (ARBITER_WIDTH=P) and consumes its one-hot grant.
- Turns a single-cycle grant into a wormhole packet lock: held from head flit to tail flit.
- Muxes the winning input's flits into a registered output and tracks downstream buffer credits.

Parameters:
- P, 5, number of input ports competing for this output (2..16).
- FW, 32, flit width in bits.
- CREDIT_DEPTH, 4, downstream buffer depth in flits (1..15); credit counter width CW = ceil(log2(CREDIT_DEPTH+1)).

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- req  in  P  per-input flit valid.
- hdr  in  P  per-input flag: current flit is a head flit.
- tail  in  P  per-input flag: current flit is a tail flit.
- flit_in  in  P*FW  per-input flit data; input i occupies bits [(i+1)*FW-1 : i*FW].
- flit_ack  out  P  one-hot; the input's flit is consumed this cycle.
- flit_out  out  FW  registered output flit.
- flit_out_valid  out  1  registered output valid.
- credit_in  in  1  downstream freed one buffer slot.
- credits  out  CW  current credit count.
- locked  out  1  port is owned by an input mid-packet.
- owner  out  P  one-hot current owner; 0 when not locked.
- credit_err  out  1  sticky overflow flag.

Behaviour:
- Reset: reset, asynchronous, active-high; clock clk. All flops are asynchronous on posedge reset.
- Reset values: state=IDLE, owner=0, locked=0, flit_out=0, flit_out_valid=0, credits=CREDIT_DEPTH, credit_err=0, arbiter pointer at its own reset value.
- has_credit = (credits != 0).
- FSM IDLE:
  - Arbiter request = req & hdr & {P{has_credit}}; arbiter priority_en = any_grant.
  - On grant g: flit_ack=g (same cycle, combinational) and the flit is transferred.
  - If tail[g] is also set (single-flit packet): stay IDLE.
  - Otherwise: go to LOCKED with owner<=g.
- FSM LOCKED:
  - The arbiter request is forced to 0; arbiter priority is not updated.
  - Transfer when (req & owner)!=0 and has_credit; flit_ack=owner.
  - Transfer with tail: go to IDLE, owner<=0, on the next edge.
  - Request without credit, or no request: hold, flit_ack=0.
  - Head flits from other inputs are ignored.
- Transfer datapath: on the cycle after a transfer, flit_out = selected flit_in slice and flit_out_valid=1.
  - flit_out_valid=0 on any cycle after a non-transfer; flit_out keeps its last value.
  - Latency is exactly 1 cycle, with no bubble between back-to-back flits.
- Credit counter:
  - Transfer only: -1. credit_in only: +1. Both in the same cycle: unchanged.
  - Never transfers at credits=0; credit_in at 0 in the same cycle does not enable a transfer.
  - credit_in with no transfer at credits==CREDIT_DEPTH: counter saturates and credit_err<=1 (sticky until reset).
- A non-head flit presented in IDLE is never acked.
- locked = (state==LOCKED); owner is a registered one-hot.
- Reset mid-packet: lock is dropped, output is invalidated, credits are restored; the upstream must restart the packet.
- At most one flit_ack bit is set per cycle.

Test Plan:
- Single 3-flit packet from input 2 (P=5, credits 4):
  - acks on cycles 0..2.
  - flit_out_valid on cycles 1..3 with data 0xA0,0xA1,0xA2.
  - locked high after cycle 0 until the tail edge.
  - credits end at 1.
- Inputs 0 and 3 both present heads of 2-flit packets:
  - First winner is taken per arbiter priority.
  - The other input is held off until the tail; it wins on the cycle after the first tail.
  - Ack sequence is 0,0,3,3 or 3,3,0,0; never interleaved.
- CREDIT_DEPTH=2, 4-flit packet, no credit_in:
  - 2 acks, then flit_ack=0 and flit_out_valid=0 while locked.
  - credit_in pulse resumes exactly one flit per credit.
- Simultaneous transfer and credit_in at credits=1: credits stays 1 and the flit is delivered.
- credit_in asserted at credits=CREDIT_DEPTH with idle inputs: credits stays at CREDIT_DEPTH, credit_err=1 and remains 1.
- Reset asserted mid-packet (after flit 1 of 3):
  - Immediately: locked=0, owner=0, flit_out_valid=0, credits=CREDIT_DEPTH.
  - A new head from another input is granted on the first cycle after reset deasserts.
